// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings,
// default latencies and the FSM state type.
package md_unit_pkg;

    // Operation codes carried on md_op. MFLO reaches the unit as MD_NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MFHI  = 3'd7
    } md_op_e;

    // Two-state controller; the down-counter tracks progress inside RUN.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_multicycle(input md_op_e op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. Multi-cycle operations latch
// their operands at the start edge and commit the result to HI/LO on the
// last busy cycle; MTHI/MTLO write on the following edge.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    md_op_e           op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;

    logic [63:0]      prod_s;
    logic [31:0]      hi_d;
    logic [31:0]      lo_d;
    logic             wr_d;
    md_op_e           op_in_s;

    assign op_in_s = md_op_e'(md_op);

    // Result of the latched operation; wr_d is low when HI/LO must be kept
    // (divide by zero or a non-arithmetic latched op).
    always_comb begin
        prod_s = 64'd0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        wr_d   = 1'b0;
        case (op_q)
            MD_MULT: begin
                prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
                hi_d   = prod_s[63:32];
                lo_d   = prod_s[31:0];
                wr_d   = 1'b1;
            end
            MD_MULTU: begin
                prod_s = {32'd0, a_q} * {32'd0, b_q};
                hi_d   = prod_s[63:32];
                lo_d   = prod_s[31:0];
                wr_d   = 1'b1;
            end
            MD_DIV: begin
                if (b_q == 32'd0) begin
                    wr_d = 1'b0;
                end else if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
                    // Most-negative / -1 wraps instead of trapping.
                    lo_d = 32'h8000_0000;
                    hi_d = 32'd0;
                    wr_d = 1'b1;
                end else begin
                    lo_d = $signed(a_q) / $signed(b_q);
                    hi_d = $signed(a_q) % $signed(b_q);
                    wr_d = 1'b1;
                end
            end
            MD_DIVU: begin
                if (b_q == 32'd0) begin
                    wr_d = 1'b0;
                end else begin
                    lo_d = a_q / b_q;
                    hi_d = a_q % b_q;
                    wr_d = 1'b1;
                end
            end
            default: begin
                wr_d = 1'b0;
            end
        endcase
    end

    // Controller: start/latch in IDLE, count down in RUN, commit HI/LO on the
    // last cycle. Reset aborts any operation without committing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_multicycle(op_in_s)) begin
                        op_q    <= op_in_s;
                        a_q     <= A;
                        b_q     <= B;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                        if ((op_in_s == MD_MULT) || (op_in_s == MD_MULTU)) begin
                            cnt_q <= CNT_W'(MULT_CYCLES);
                        end else begin
                            cnt_q <= CNT_W'(DIV_CYCLES);
                        end
                    end else if (start && (op_in_s == MD_MTHI)) begin
                        hi_q <= A;
                    end else if (start && (op_in_s == MD_MTLO)) begin
                        lo_q <= A;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A start here is ignored; operands stay as latched.
                    if (cnt_q == CNT_W'(1)) begin
                        if (wr_d) begin
                            hi_q <= hi_d;
                            lo_q <= lo_d;
                        end else begin
                            hi_q <= hi_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
